// File: rtl/match_controller_if.sv
// Signal bundle between the round/match sequencer and the game datapath
// (health blocks, box, rom_port_data, box_color).
interface match_controller_if;
    logic        vsync;
    logic [31:0] keycodes;
    logic        p1_lose;
    logic        p2_lose;
    logic [6:0]  p1_health;
    logic [6:0]  p2_health;
    logic [2:0]  game_mode;
    logic [2:0]  state_out;
    logic [8:0]  count;
    logic [7:0]  round_time;
    logic [2:0]  round_num;
    logic [1:0]  p1_rounds;
    logic [1:0]  p2_rounds;
    logic [1:0]  match_winner;
    logic        freeze;
    logic        round_reset;

    modport master (
        input  vsync, keycodes, p1_lose, p2_lose, p1_health, p2_health,
        output game_mode, state_out, count, round_time, round_num,
               p1_rounds, p2_rounds, match_winner, freeze, round_reset
    );

    modport slave (
        output vsync, keycodes, p1_lose, p2_lose, p1_health, p2_health,
        input  game_mode, state_out, count, round_time, round_num,
               p1_rounds, p2_rounds, match_winner, freeze, round_reset
    );
endinterface

// File: rtl/match_controller.sv
// Round/match sequencer: turns both fighters' lose flags and health into the
// game mode, BCD round timer, banner/KO animation count and win tallies.
//
// state | meaning
// TITLE | waiting for a mode key (1E vs AI, 1F two-player)
// INTRO | "ROUND n" banner, count runs 0..INTRO_FRAMES-1
// FIGHT | fighters live, round timer counts down
// KO    | round decided, count runs up to KO_FRAMES
// OVER  | match decided, waiting for key 15
module match_controller #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECS     = 99,
    parameter int INTRO_FRAMES   = 90,
    parameter int KO_FRAMES      = 50,
    parameter int WINS_NEEDED    = 2,
    parameter int MAX_ROUNDS     = 5
) (
    input logic                Clk,
    input logic                Reset_n,
    match_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_INTRO = 3'd1,
        S_FIGHT = 3'd2,
        S_KO    = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int               DIV_W      = $clog2(FRAMES_PER_SEC + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAMES_PER_SEC - 1);
    localparam logic [7:0]       ROUND_BCD  = 8'(((ROUND_SECS / 10) * 16) + (ROUND_SECS % 10));
    localparam logic [8:0]       INTRO_LAST = 9'(INTRO_FRAMES - 1);
    localparam logic [8:0]       KO_LAST    = 9'(KO_FRAMES);
    localparam logic [1:0]       WINS_REQ   = 2'(WINS_NEEDED);
    localparam logic [2:0]       LAST_ROUND = 3'(MAX_ROUNDS);
    localparam logic [7:0]       KEY_AI     = 8'h1E;
    localparam logic [7:0]       KEY_2P     = 8'h1F;
    localparam logic [7:0]       KEY_BACK   = 8'h15;
    localparam logic [2:0]       MODE_TITLE = 3'b000;
    localparam logic [2:0]       MODE_AI    = 3'b001;
    localparam logic [2:0]       MODE_2P    = 3'b010;

    state_t           state, state_nxt;
    logic             vsync_d;
    logic             frame_tick;
    logic [2:0]       game_mode, game_mode_nxt;
    logic [8:0]       count, count_nxt;
    logic [7:0]       round_time, round_time_nxt;
    logic [DIV_W-1:0] divider, divider_nxt;
    logic [2:0]       round_num, round_num_nxt;
    logic [1:0]       p1_rounds, p1_rounds_nxt;
    logic [1:0]       p2_rounds, p2_rounds_nxt;
    logic [1:0]       match_winner, match_winner_nxt;
    logic             freeze, freeze_nxt;
    logic             round_reset, round_reset_nxt;

    logic             key_ai, key_2p, key_back;
    logic             enter_intro;
    logic             round_over;
    logic             award_p1, award_p2;

    function automatic logic key_hit(input logic [31:0] keys, input logic [7:0] code);
        key_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keys[8*i +: 8] == code) key_hit = 1'b1;
        end
    endfunction

    // Counts down in BCD and parks at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            bcd_dec = 8'h00;
        else if (v[3:0] == 4'd0)
            bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else
            bcd_dec = {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        sat_inc = (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    assign frame_tick = bus.vsync & ~vsync_d;
    assign key_ai     = key_hit(bus.keycodes, KEY_AI);
    assign key_2p     = key_hit(bus.keycodes, KEY_2P);
    assign key_back   = key_hit(bus.keycodes, KEY_BACK);

    always_comb begin
        state_nxt        = state;
        game_mode_nxt    = game_mode;
        count_nxt        = count;
        round_time_nxt   = round_time;
        divider_nxt      = divider;
        round_num_nxt    = round_num;
        p1_rounds_nxt    = p1_rounds;
        p2_rounds_nxt    = p2_rounds;
        match_winner_nxt = match_winner;
        freeze_nxt       = freeze;
        round_reset_nxt  = 1'b0;
        enter_intro      = 1'b0;
        round_over       = 1'b0;
        award_p1         = 1'b0;
        award_p2         = 1'b0;

        if (frame_tick) begin
            case (state)
                S_TITLE: begin
                    if (key_ai || key_2p) begin
                        game_mode_nxt = key_ai ? MODE_AI : MODE_2P;
                        p1_rounds_nxt = 2'd0;
                        p2_rounds_nxt = 2'd0;
                        round_num_nxt = 3'd1;
                        enter_intro   = 1'b1;
                    end
                end
                S_INTRO: begin
                    if (count == INTRO_LAST) begin
                        state_nxt  = S_FIGHT;
                        count_nxt  = 9'd0;
                        freeze_nxt = 1'b0;
                    end else begin
                        count_nxt = count + 9'd1;
                    end
                end
                S_FIGHT: begin
                    // Lose flags take priority over the timeout; both set is a draw.
                    if (bus.p1_lose || bus.p2_lose) begin
                        round_over = 1'b1;
                        award_p1   = bus.p2_lose & ~bus.p1_lose;
                        award_p2   = bus.p1_lose & ~bus.p2_lose;
                    end else if (round_time == 8'h00) begin
                        round_over = 1'b1;
                        award_p1   = bus.p1_health > bus.p2_health;
                        award_p2   = bus.p2_health > bus.p1_health;
                    end

                    if (round_over) begin
                        state_nxt  = S_KO;
                        count_nxt  = 9'd0;
                        freeze_nxt = 1'b1;
                        if (award_p1) p1_rounds_nxt = sat_inc(p1_rounds);
                        if (award_p2) p2_rounds_nxt = sat_inc(p2_rounds);
                    end else if (divider == DIV_LAST) begin
                        divider_nxt    = '0;
                        round_time_nxt = bcd_dec(round_time);
                    end else begin
                        divider_nxt = divider + 1'b1;
                    end
                end
                S_KO: begin
                    if (count == KO_LAST) begin
                        if (p1_rounds >= WINS_REQ || p2_rounds >= WINS_REQ ||
                            round_num == LAST_ROUND) begin
                            state_nxt = S_OVER;
                            if (p1_rounds > p2_rounds)
                                match_winner_nxt = 2'b01;
                            else if (p2_rounds > p1_rounds)
                                match_winner_nxt = 2'b10;
                            else
                                match_winner_nxt = 2'b11;
                        end else begin
                            round_num_nxt = round_num + 3'd1;
                            enter_intro   = 1'b1;
                        end
                    end else begin
                        count_nxt = count + 9'd1;
                    end
                end
                S_OVER: begin
                    if (key_back) begin
                        state_nxt        = S_TITLE;
                        game_mode_nxt    = MODE_TITLE;
                        match_winner_nxt = 2'b00;
                        p1_rounds_nxt    = 2'd0;
                        p2_rounds_nxt    = 2'd0;
                        count_nxt        = 9'd0;
                    end
                end
                default: state_nxt = S_TITLE;
            endcase
        end

        if (enter_intro) begin
            state_nxt       = S_INTRO;
            round_reset_nxt = 1'b1;
            round_time_nxt  = ROUND_BCD;
            divider_nxt     = '0;
            count_nxt       = 9'd0;
            freeze_nxt      = 1'b1;
        end
    end

    // vsync_d resets high so a vsync already high at release is not a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_TITLE;
            vsync_d      <= 1'b1;
            game_mode    <= MODE_TITLE;
            count        <= 9'd0;
            round_time   <= ROUND_BCD;
            divider      <= '0;
            round_num    <= 3'd1;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            match_winner <= 2'b00;
            freeze       <= 1'b1;
            round_reset  <= 1'b0;
        end else begin
            state        <= state_nxt;
            vsync_d      <= bus.vsync;
            game_mode    <= game_mode_nxt;
            count        <= count_nxt;
            round_time   <= round_time_nxt;
            divider      <= divider_nxt;
            round_num    <= round_num_nxt;
            p1_rounds    <= p1_rounds_nxt;
            p2_rounds    <= p2_rounds_nxt;
            match_winner <= match_winner_nxt;
            freeze       <= freeze_nxt;
            round_reset  <= round_reset_nxt;
        end
    end

    assign bus.game_mode    = game_mode;
    assign bus.state_out    = state;
    assign bus.count        = count;
    assign bus.round_time   = round_time;
    assign bus.round_num    = round_num;
    assign bus.p1_rounds    = p1_rounds;
    assign bus.p2_rounds    = p2_rounds;
    assign bus.match_winner = match_winner;
    assign bus.freeze       = freeze;
    assign bus.round_reset  = round_reset;

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer for the two-fighter game.
- Sits downstream of both p1_health instances: consumes their lose flags and health levels.
- Sits upstream of box, rom_port_data and box_color: drives game_mode, the shared KO animation count, the round timer and the round-win tallies.
- Replaces the ad hoc count logic at top level and the game_mode source in the SoC.

Parameters:
- FRAMES_PER_SEC, 60, frame ticks per timer decrement
- ROUND_SECS, 99, round length; stored as BCD, max 99
- INTRO_FRAMES, 90, length of the "ROUND n" banner
- KO_FRAMES, 50, count saturation value after a KO
- WINS_NEEDED, 2, round wins needed to take the match
- MAX_ROUNDS, 5, round limit before a forced match end

Ports:
- Clk  in  1  50 MHz system clock (MAX10_CLK1_50)
- Reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  VGA_VS from vga_controller, synchronous to Clk
- keycodes  in  32  four USB keycodes; a key is "pressed" when any byte equals its code
- p1_lose, p2_lose  in  1  health-depleted flags
- p1_health, p2_health  in  7  remaining health, 0..100
- game_mode  out  3  000 title, 001 vs AI, 010 two-player
- state_out  out  3  current FSM state, for box_color screen selection
- count  out  9  frame counter for banner/KO animation
- round_time  out  8  BCD seconds remaining
- round_num  out  3  current round, 1-based
- p1_rounds, p2_rounds  out  2  round wins
- match_winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- freeze  out  1  fighters ignore input while high
- round_reset  out  1  one-Clk pulse that reinitialises box/p1_health

Behaviour:
- frame_tick = vsync & ~vsync_d. vsync_d is registered on Clk and resets to 1, so no tick is produced immediately out of reset. Keycodes and lose flags are sampled only on frame_tick.
- Reset values: state TITLE, game_mode 000, count 0, round_time 8'h99, round_num 1, rounds 0, match_winner 00, freeze 1, round_reset 0.
- States:
  - TITLE (0): key 8'h1E selects mode 001, key 8'h1F selects mode 010; both pressed means 1E wins. On selection: clear tallies, set round_num=1, go to INTRO.
  - INTRO (1): freeze=1, count increments per tick. On the tick where count==INTRO_FRAMES-1, go to FIGHT.
  - FIGHT (2): freeze=0. A frame divider counts 0..FRAMES_PER_SEC-1; round_time decrements in BCD on wrap (09 becomes 08, 10 becomes 09) and never goes below 00.
    - On a tick: p1_lose=1 and p2_lose=0 awards P2. p2_lose=1 and p1_lose=0 awards P1. Both high is a draw round with no award.
    - Otherwise, if round_time==00: the higher health wins; equal health is a draw round.
    - Any of these outcomes goes to KO.
  - KO (3): freeze=1, count restarts at 0 and increments per tick, saturating at KO_FRAMES. The winner's tally increments on KO entry (2-bit, saturating at 3). On the tick where count==KO_FRAMES:
    - if either tally ≥ WINS_NEEDED, or round_num==MAX_ROUNDS, go to OVER;
    - else round_num+1, go to INTRO.
  - OVER (4): match_winner is set on entry to the higher tally, or 11 if tallies are equal. count holds KO_FRAMES. Key 8'h15 returns to TITLE with game_mode 000, match_winner 00 and tallies cleared.
- Key 8'h15 in any state other than TITLE or OVER is ignored.
- On every transition into INTRO: round_reset pulses high for exactly one Clk, round_time=99, divider=0, count=0.
- count is 0 in TITLE and FIGHT.
- game_mode is held constant from TITLE exit until OVER exit.
- Reset_n asserted mid-match: everything returns to reset values immediately (asynchronous); round_reset is not pulsed.
- All outputs are registered.

Test Plan:
- Reset, then 3 vsync pulses with no key → state TITLE, game_mode 000, freeze 1, count 0.
- Key 1E in keycodes[15:8] → one round_reset pulse; INTRO with count climbing to 89; FIGHT on the 90th tick with round_time 99, which reads 98 after 60 ticks.
- In FIGHT, assert p2_lose for one tick → KO, p1_rounds 1, count saturates at 50, then INTRO with round_num 2. Repeat the KO → OVER, match_winner 01. Key 15 → TITLE, tallies 0.
- Timeout: hold 99×60 ticks, p1_health 40, p2_health 55 → round_time 00, KO, p2_rounds 1. Same with equal health → draw round, no tally change.
- p1_lose and p2_lose on the same tick in round 5 with tallies 1/1 → OVER, match_winner 11.
- Reset_n low mid-FIGHT (round_time 57) → all outputs take reset values within the same cycle. Key 1F after release → game_mode 010.
